// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus debug bridge: parser states and
// the command/response byte codes of the host protocol.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4
  } bridgeState_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

endpackage

// File: rtl/uart_bridge_tx_ser.sv
// Response serializer: takes up to five bytes (MSB first) and walks them
// through the transmitter's tx_valid/tx_done handshake one byte at a time.
module uart_bridge_tx_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [39:0] loadBytes,
  input  logic [2:0]  loadCount,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [31:0] tailBytes;
  logic [2:0]  remaining;
  logic        waiting;

  // done fires in the same cycle the last byte's tx_done arrives
  assign done = waiting && tx_done && (remaining == 3'd1);

  // Byte sequencing: next tx_valid goes out the cycle after each tx_done
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      tailBytes <= 32'h0000_0000;
      remaining <= 3'd0;
      waiting   <= 1'b0;
    end else if (load) begin
      tx_data   <= loadBytes[39:32];
      tailBytes <= loadBytes[31:0];
      remaining <= loadCount;
      waiting   <= 1'b1;
      tx_valid  <= 1'b1;
    end else if (waiting && tx_done) begin
      if (remaining == 3'd1) begin
        waiting   <= 1'b0;
        remaining <= 3'd0;
        tx_valid  <= 1'b0;
      end else begin
        tx_data   <= tailBytes[31:24];
        tailBytes <= {tailBytes[23:0], 8'h00};
        remaining <= remaining - 3'd1;
        tx_valid  <= 1'b1;
      end
    end else begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug bridge: parses host command frames, performs one 32-bit
// bus read or write, and answers with an OK/ERR response frame.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int FrameTimeout = 100000,
  parameter int BusTimeout   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_done,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [3:0]  bus_strobe,
  input  logic [31:0] bus_rdata,
  input  logic        bus_request_stall,
  input  logic        bus_error,
  output logic        busy,
  output logic        overrun
);

  localparam logic [31:0] FrameLimit = 32'(FrameTimeout - 1);
  localparam logic [31:0] StallLimit = 32'(BusTimeout - 1);

  bridgeState_t state, stateNext;
  logic        isWrite;
  logic [1:0]  byteCnt;
  logic [31:0] frameTimer;
  logic [31:0] stallCnt;
  logic        busActive;
  logic        busAccept;
  logic        busAbort;
  logic        txLoad;
  logic        txAllDone;
  logic [39:0] txBytes;
  logic [2:0]  txCount;

  assign busActive = bus_ren | bus_wen;
  assign txLoad    = busAccept | busAbort;

  // Next-state decode for the frame parser / bus / response sequence
  always_comb begin
    stateNext = state;
    busAccept = 1'b0;
    busAbort  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
          stateNext = ADDR;
        end else begin
          stateNext = IDLE;
        end
      end
      ADDR: begin
        if (rx_err || (!rx_done && (frameTimer == FrameLimit))) begin
          stateNext = IDLE;
        end else if (rx_done && (byteCnt == 2'd3)) begin
          stateNext = isWrite ? WDATA : BUS;
        end else begin
          stateNext = ADDR;
        end
      end
      WDATA: begin
        if (rx_err || (!rx_done && (frameTimer == FrameLimit))) begin
          stateNext = IDLE;
        end else if (rx_done && (byteCnt == 2'd3)) begin
          stateNext = BUS;
        end else begin
          stateNext = WDATA;
        end
      end
      BUS: begin
        // the request is only raised one cycle after entry, so wait for it
        if (!busActive) begin
          stateNext = BUS;
        end else if (!bus_request_stall) begin
          busAccept = 1'b1;
          stateNext = RESP;
        end else if (stallCnt == StallLimit) begin
          busAbort  = 1'b1;
          stateNext = RESP;
        end else begin
          stateNext = BUS;
        end
      end
      RESP: begin
        if (txAllDone) begin
          stateNext = IDLE;
        end else begin
          stateNext = RESP;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Response frame selection, loaded into the serializer on leaving BUS
  always_comb begin
    txBytes = {RSP_OK, 32'h0000_0000};
    txCount = 3'd1;
    if (busAbort || bus_error) begin
      txBytes = {RSP_ERR, 32'h0000_0000};
      txCount = 3'd1;
    end else if (!isWrite) begin
      txBytes = {RSP_OK, bus_rdata};
      txCount = 3'd5;
    end else begin
      txBytes = {RSP_OK, 32'h0000_0000};
      txCount = 3'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Datapath: address/data shifting, counters and bus request handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      isWrite    <= 1'b0;
      byteCnt    <= 2'd0;
      frameTimer <= 32'd0;
      stallCnt   <= 32'd0;
      bus_addr   <= 32'h0000_0000;
      bus_wdata  <= 32'h0000_0000;
      bus_ren    <= 1'b0;
      bus_wen    <= 1'b0;
      bus_strobe <= 4'h0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      busy <= (stateNext != IDLE);
      if (rx_done && ((state == BUS) || (state == RESP))) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          byteCnt    <= 2'd0;
          frameTimer <= 32'd0;
          if (stateNext == ADDR) begin
            isWrite <= (rx_data == CMD_WRITE);
          end
        end
        ADDR, WDATA: begin
          if (rx_done) begin
            if (state == ADDR) begin
              bus_addr <= {bus_addr[23:0], rx_data};
            end else begin
              bus_wdata <= {bus_wdata[23:0], rx_data};
            end
            byteCnt    <= byteCnt + 2'd1;
            frameTimer <= 32'd0;
          end else begin
            frameTimer <= frameTimer + 32'd1;
          end
        end
        BUS: begin
          if (!busActive) begin
            bus_ren    <= ~isWrite;
            bus_wen    <= isWrite;
            bus_strobe <= 4'hF;
            stallCnt   <= 32'd0;
          end else if (busAccept || busAbort) begin
            bus_ren    <= 1'b0;
            bus_wen    <= 1'b0;
            bus_strobe <= 4'h0;
          end else begin
            stallCnt <= stallCnt + 32'd1;
          end
        end
        RESP: begin
          byteCnt <= 2'd0;
        end
        default: begin
          byteCnt <= 2'd0;
        end
      endcase
    end
  end

  uart_bridge_tx_ser txSer (
    .clk       (clk),
    .reset     (reset),
    .load      (txLoad),
    .loadBytes (txBytes),
    .loadCount (txCount),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .done      (txAllDone)
  );

endmodule
